// File: rtl/rc4_seq_ctrl.sv
// Sequencer for an RC4 keystream job: S-box init sweep, parameter check,
// core enable, capture of num_bytes keystream bytes into a FWFT output FIFO.
module rc4_seq_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SBOX_SIZE  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic        abort,
  input  logic [31:0] key,
  input  logic [7:0]  key_length,
  input  logic [7:0]  num_bytes,
  output logic        init_wen,
  output logic [7:0]  init_addr,
  output logic [7:0]  init_wdata,
  output logic        core_start,
  output logic        core_hold,
  input  logic        core_ks_valid,
  input  logic [7:0]  core_ks_data,
  output logic [31:0] core_key,
  output logic [7:0]  core_key_length,
  output logic [7:0]  ks_data,
  output logic        ks_valid,
  input  logic        ks_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ovf
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_HOLD  = OCC_W'(FIFO_DEPTH - 1);
  localparam logic [7:0]       INIT_LAST = 8'(SBOX_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state;
  logic [7:0]         num_bytes_q;
  logic [7:0]         cap_cnt;
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [OCC_W-1:0]   occ;

  logic               abort_hit;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               capture;
  logic               push_ok;
  logic               drop;
  logic [7:0]         cap_inc;

  // FIFO status and the handshake decisions for this cycle
  assign abort_hit  = abort && (state != S_IDLE);
  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == OCC_FULL);
  assign ks_valid   = !fifo_empty;
  assign ks_data    = fifo_mem[rd_ptr];
  assign pop        = ks_valid && ks_ready;
  assign core_hold  = (occ >= OCC_HOLD) && !pop;

  // Bytes beyond num_bytes are ignored; a full FIFO without a pop drops the byte
  assign capture = (state == S_RUN) && core_ks_valid && (cap_cnt != num_bytes_q) && !abort_hit;
  assign push_ok = capture && (!fifo_full || pop);
  assign drop    = capture && fifo_full && !pop;
  assign cap_inc = 8'(cap_cnt + 8'd1);

  // Output FIFO storage and pointers; abort flushes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (abort_hit) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= core_ks_data;
        wr_ptr           <= PTR_W'(wr_ptr + 1'b1);
      end
      if (pop) begin
        rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      end
      case ({push_ok, pop})
        2'b10:   occ <= OCC_W'(occ + 1'b1);
        2'b01:   occ <= OCC_W'(occ - 1'b1);
        default: occ <= occ;
      endcase
    end
  end

  // Job sequencer with registered status and core-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      num_bytes_q     <= '0;
      cap_cnt         <= '0;
      init_wen        <= 1'b0;
      init_addr       <= '0;
      init_wdata      <= '0;
      core_start      <= 1'b0;
      core_key        <= '0;
      core_key_length <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      ovf             <= 1'b0;
    end else if (abort_hit) begin
      state      <= S_IDLE;
      cap_cnt    <= '0;
      init_wen   <= 1'b0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            state           <= S_INIT;
            core_key        <= key;
            core_key_length <= key_length;
            num_bytes_q     <= num_bytes;
            cap_cnt         <= '0;
            init_wen        <= 1'b1;
            init_addr       <= '0;
            init_wdata      <= '0;
            busy            <= 1'b1;
            ovf             <= 1'b0;
          end
        end
        S_INIT: begin
          if (init_addr == INIT_LAST) begin
            state    <= S_LOAD;
            init_wen <= 1'b0;
          end else begin
            init_addr  <= 8'(init_addr + 8'd1);
            init_wdata <= 8'(init_wdata + 8'd1);
          end
        end
        S_LOAD: begin
          if ((core_key_length == 8'd0) || (core_key_length > 8'd4) || (num_bytes_q == 8'd0)) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else begin
            state      <= S_RUN;
            core_start <= 1'b1;
          end
        end
        S_RUN: begin
          if (push_ok) begin
            cap_cnt <= cap_inc;
          end
          if (drop) begin
            ovf <= 1'b1;
          end
          if ((push_ok && (cap_inc == num_bytes_q)) || (cap_cnt == num_bytes_q)) begin
            state      <= S_DRAIN;
            core_start <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (fifo_empty) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        S_ERR: begin
          state <= S_IDLE;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          init_wen   <= 1'b0;
          core_start <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          err        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rc4_seq_ctrl.md
RC4_SEQ_CTRL -- requirements
Module: rc4_seq_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the keystream output FIFO depth in entries; legal values are powers of two, 2 to 16.
REQ-002 SHALL have parameter SBOX_SIZE, default 256, the number of S-box entries initialised.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_start, input, 1 bit: a one-cycle request to run a keystream job.
REQ-006 SHALL have port abort, input, 1 bit: cancels the current job.
REQ-007 SHALL have port key, input, 32 bits: key bytes, byte 0 = key[7:0].
REQ-008 SHALL have port key_length, input, 8 bits: key length in bytes; legal range 1..4.
REQ-009 SHALL have port num_bytes, input, 8 bits: the number of keystream bytes to deliver; legal range 1..255.
REQ-010 SHALL have ports init_wen (1), init_addr (8) and init_wdata (8), all outputs: the S-box initialisation write port.
REQ-011 SHALL have port core_start, output, 1 bit: enables the RC4 core.
REQ-012 SHALL have port core_hold, output, 1 bit: backpressure to the core.
REQ-013 SHALL have ports core_ks_valid (1) and core_ks_data (8), both inputs: the keystream byte strobe from the core.
REQ-014 SHALL have ports core_key (32) and core_key_length (8), both outputs: the latched job parameters.
REQ-015 SHALL have ports ks_data (8) and ks_valid (1), outputs, and ks_ready (1), input: the keystream output stream.
REQ-016 SHALL have ports busy, done, err and ovf, all outputs, 1 bit each: job status.

Function
REQ-017 SHALL implement the states IDLE, INIT, LOAD, RUN, DRAIN, DONE and ERR.
REQ-018 IDLE: a cmd_start sampled high SHALL latch key, key_length and num_bytes and enter INIT on the next cycle; busy is high in every state except IDLE.
REQ-019 INIT: for SBOX_SIZE consecutive cycles, init_wen=1 and init_addr=init_wdata=n, for n = 0..SBOX_SIZE-1; the state then goes to LOAD.
REQ-020 LOAD, which lasts 1 cycle: if latched key_length is 0 or greater than 4, or num_bytes is 0, the state goes to ERR; otherwise it goes to RUN.
REQ-021 ERR, which lasts 1 cycle: err=1, no keystream is produced, and the state returns to IDLE.
REQ-022 RUN: core_start=1 for the whole state; each cycle with core_ks_valid=1 pushes core_ks_data into the FIFO and increments an 8-bit capture counter.
REQ-023 RUN SHALL go to DRAIN in the cycle after the capture counter reaches num_bytes; core_start drops to 0 in that same cycle.
REQ-024 RUN: a core_ks_valid that arrives after the counter equals num_bytes SHALL be ignored.
REQ-025 DRAIN SHALL wait until the FIFO is empty and then enter DONE.
REQ-026 DONE: done=1 for exactly 1 cycle, then the state returns to IDLE.
REQ-027 The FIFO SHALL be first-word-fall-through: ks_valid = not empty, and ks_data = the head entry.
REQ-028 The FIFO SHALL pop on ks_valid and ks_ready both high.
REQ-029 A push and a pop in the same cycle SHALL leave the occupancy unchanged, and this is legal when the FIFO is full.
REQ-030 core_hold SHALL be combinational and equal to 1 when occupancy >= FIFO_DEPTH-1 and no pop occurs in that cycle.
REQ-031 A push while the FIFO is full with no pop SHALL drop the byte, set the sticky ovf, and leave the counter unchanged; ovf clears on the next cmd_start accepted.
REQ-032 cmd_start while busy=1 SHALL be ignored.
REQ-033 abort=1 in any non-IDLE state SHALL take effect next cycle: state becomes IDLE, the FIFO is flushed, core_start=0, and neither done nor err is pulsed.
REQ-034 Abort SHALL have priority over every other transition in the same cycle.
REQ-035 init_addr and the capture counter SHALL be 8-bit; the counter saturates at num_bytes and never wraps.

Reset
REQ-036 While rst_n=0, all of the following SHALL hold: state IDLE, FIFO empty, counter 0, and outputs busy, done, err, ovf, init_wen, core_start, core_hold and ks_valid all 0.
REQ-037 While rst_n=0, init_addr, init_wdata, ks_data, core_key and core_key_length SHALL all be 0.
REQ-038 Reset assertion mid-job SHALL behave as an abort and clear ovf.
REQ-039 After rst_n deasserts, the first cmd_start SHALL be accepted on the first rising edge.

Verification
REQ-040 Nominal run: cmd_start with key=0x04030201, key_length=4, num_bytes=8, and ks_ready=1 -> init_wen is high for exactly 256 cycles (addresses 0..255), core_start rises on the 258th cycle after cmd_start, 8 bytes are output in core order, and done pulses 1 cycle after the FIFO empties.
REQ-041 Illegal parameters: key_length=5 -> after INIT, err pulses 1 cycle, core_start never rises, and busy falls the next cycle.
REQ-042 Backpressure: ks_ready=0 while the core supplies 10 bytes with FIFO_DEPTH=4 -> core_hold=1 at occupancy 3, no ovf, then ks_ready=1 delivers all 10 bytes in order.
REQ-043 Overflow: the core ignores core_hold and pushes 5 bytes with ks_ready=0 -> the 5th byte is dropped, ovf=1, and ovf stays 1 through done.
REQ-044 Abort: abort during RUN after 3 bytes are captured -> the next cycle shows busy=0, ks_valid=0 and core_start=0, with no done; a following cmd_start restarts from INIT at address 0.
REQ-045 Reset: rst_n pulsed low mid-INIT at init_addr=100 -> all outputs take the REQ-036 and REQ-037 values, asynchronously.
